uart_tx_buffer: RTL

- Writer side of the 4-byte TX buffer that the seven-segment page viewer displays.
- Bytes are entered from the 8 slide switches and shifted into a 4-entry byte buffer with a load button.
- A send button serialises all four bytes, oldest first, onto the UART TX pin (8N1).
- The buffer contents are exported continuously so the display block can show TXBUF while this block owns it.

---
 rtl/uart_tx_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: 4-byte switch-loaded buffer, sent oldest-first over an 8N1 UART line.
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                sw,
    input  logic                      load_btn,
    input  logic                      send_btn,
    output logic [NUM_BYTES-1:0][7:0] txbuf,
    output logic                      tx,
    output logic                      busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                    state, state_n;
    logic [CW-1:0]             baud, baud_n;
    logic [2:0]                bit_idx, bit_n;
    logic [BW-1:0]             byte_idx, byte_n, sel;
    logic [NUM_BYTES-1:0][7:0] shadow, shadow_n, txbuf_n;
    logic                      tx_n, bit_end;
    logic [1:0]                load_sync, send_sync;
    logic                      load_prev, send_prev, load_edge, send_edge;

    assign load_edge = load_sync[1] & ~load_prev;
    assign send_edge = send_sync[1] & ~send_prev;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shadow    <= '0;
            txbuf     <= '0;
            tx        <= 1'b1;
            load_sync <= '0;
            send_sync <= '0;
            load_prev <= 1'b0;
            send_prev <= 1'b0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_idx   <= bit_n;
            byte_idx  <= byte_n;
            shadow    <= shadow_n;
            txbuf     <= txbuf_n;
            tx        <= tx_n;
            load_sync <= {load_sync[0], load_btn};
            send_sync <= {send_sync[0], send_btn};
            load_prev <= load_sync[1];
            send_prev <= send_sync[1];
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_idx;
        byte_n   = byte_idx;
        shadow_n = shadow;
        txbuf_n  = txbuf;
        bit_end  = baud == CW'(CLKS_PER_BIT - 1);
        baud_n   = (state == IDLE || bit_end) ? '0 : baud + 1'b1;
        case (state)
            IDLE: begin
                // send has priority; a coincident load is dropped
                if (send_edge) begin
                    state_n  = START;
                    shadow_n = txbuf;
                    byte_n   = '0;
                end else if (load_edge) begin
                    txbuf_n = {txbuf[NUM_BYTES-2:0], sw};
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_n   = bit_idx + 1'b1;
                    state_n = (bit_idx == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = (byte_idx < BW'(NUM_BYTES - 1)) ? START : IDLE;
                    byte_n  = (byte_idx < BW'(NUM_BYTES - 1)) ? byte_idx + 1'b1 : byte_idx;
                end
            end
            default: state_n = IDLE;
        endcase
        // oldest byte (highest index) goes out first
        sel  = BW'(NUM_BYTES - 1) - byte_n;
        tx_n = (state_n == START) ? 1'b0 :
               (state_n == DATA)  ? shadow_n[sel][bit_n] : 1'b1;
    end
endmodule
